// File: rtl/bayer_stream_tx.sv
// Raw-Bayer frame transmitter feeding the processing pipeline input.
// Emits a newFrame pulse, a pre-frame idle gap, height rows of width pixels
// pulled from an upstream valid/ready source (each row followed by blanking),
// then zero-data flush rows until the pipeline reports done or the flush limit
// is reached.
//
// Upstream handshake: a pixel moves on a rising edge where sValid and sReady
// are both high. sReady is high exactly while the FSM is in ACTIVE and does
// not depend on sValid. The source keeps sData stable while sValid is high
// and the pixel has not yet been taken.
module bayer_stream_tx #(
  parameter int width        = 320,
  parameter int height       = 240,
  parameter int preFrameIdle = 32,
  parameter int rowBlank     = 16,
  parameter int maxFlushRows = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       sValid,
  input  logic [7:0] sData,
  output logic       sReady,
  output logic       newFrame,
  output logic       oValid,
  output logic [7:0] oData,
  input  logic       iDone,
  output logic       busy,
  output logic       frameDone,
  output logic       timeout,
  output logic [2:0] dbg_state
);

  localparam int COL_W   = $clog2(width > 1 ? width : 2);
  localparam int ROW_W   = $clog2(height > 1 ? height : 2);
  localparam int BLK_MAX = (preFrameIdle > rowBlank) ? preFrameIdle : rowBlank;
  localparam int BLK_W   = $clog2(BLK_MAX > 1 ? BLK_MAX : 2);
  localparam int FR_W    = $clog2(maxFlushRows + 1);

  // The first ACTIVE cycle is itself an idle output cycle (the accepted pixel
  // appears one cycle later), so PRE lasts one cycle less than the gap.
  localparam int PRE_LAST_I = (preFrameIdle > 1) ? preFrameIdle - 2 : 0;

  localparam logic [COL_W-1:0] COL_LAST   = COL_W'(width - 1);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(height - 1);
  localparam logic [BLK_W-1:0] PRE_LAST   = BLK_W'(PRE_LAST_I);
  localparam logic [BLK_W-1:0] BLANK_LAST = BLK_W'(rowBlank - 1);
  localparam logic [FR_W-1:0]  FR_LIMIT   = FR_W'(maxFlushRows);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SOF    = 3'd1,
    S_PRE    = 3'd2,
    S_ACTIVE = 3'd3,
    S_HBLANK = 3'd4,
    S_FLUSH  = 3'd5,
    S_FBLANK = 3'd6,
    S_DONE   = 3'd7
  } state_t;

  state_t           state, state_d;
  logic [COL_W-1:0] col, col_d;
  logic [ROW_W-1:0] row, row_d;
  logic [BLK_W-1:0] blk, blk_d;
  logic [FR_W-1:0]  frows, frows_d, frows_inc;
  logic             done_seen, done_seen_d;
  logic             timeout_d, new_frame_d, o_valid_d, frame_done_d;
  logic [7:0]       o_data_d;
  logic             in_flush, done_now, xfer;

  assign sReady    = (state == S_ACTIVE);
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  assign xfer      = sValid & sReady;
  assign in_flush  = (state == S_FLUSH) || (state == S_FBLANK);
  // iDone on the final FBLANK cycle still counts as seen during FBLANK.
  assign done_now  = done_seen | (iDone & in_flush);
  assign frows_inc = frows + FR_W'(1);

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_d      = state;
    col_d        = col;
    row_d        = row;
    blk_d        = blk;
    frows_d      = frows;
    done_seen_d  = done_seen | (iDone & in_flush);
    timeout_d    = timeout;
    new_frame_d  = 1'b0;
    o_valid_d    = 1'b0;
    o_data_d     = oData;
    frame_done_d = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_d     = S_SOF;
          col_d       = '0;
          row_d       = '0;
          blk_d       = '0;
          frows_d     = '0;
          done_seen_d = 1'b0;
          timeout_d   = 1'b0;
          new_frame_d = 1'b1;
        end
      end
      S_SOF: begin
        blk_d   = '0;
        state_d = (preFrameIdle > 1) ? S_PRE : S_ACTIVE;
      end
      S_PRE: begin
        if (blk == PRE_LAST) begin
          blk_d   = '0;
          state_d = S_ACTIVE;
        end else begin
          blk_d = blk + BLK_W'(1);
        end
      end
      S_ACTIVE: begin
        if (xfer) begin
          o_valid_d = 1'b1;
          o_data_d  = sData;
          if (col == COL_LAST) begin
            col_d   = '0;
            blk_d   = '0;
            state_d = S_HBLANK;
          end else begin
            col_d = col + COL_W'(1);
          end
        end
      end
      S_HBLANK: begin
        if (blk == BLANK_LAST) begin
          blk_d = '0;
          if (row == ROW_LAST) begin
            col_d   = '0;
            state_d = S_FLUSH;
          end else begin
            row_d   = row + ROW_W'(1);
            state_d = S_ACTIVE;
          end
        end else begin
          blk_d = blk + BLK_W'(1);
        end
      end
      S_FLUSH: begin
        o_valid_d = 1'b1;
        o_data_d  = 8'd0;
        if (col == COL_LAST) begin
          col_d   = '0;
          blk_d   = '0;
          state_d = S_FBLANK;
        end else begin
          col_d = col + COL_W'(1);
        end
      end
      S_FBLANK: begin
        if (blk == BLANK_LAST) begin
          blk_d   = '0;
          frows_d = frows_inc;
          if (done_now) begin
            state_d      = S_DONE;
            frame_done_d = 1'b1;
          end else if (frows_inc == FR_LIMIT) begin
            timeout_d    = 1'b1;
            state_d      = S_DONE;
            frame_done_d = 1'b1;
          end else begin
            state_d = S_FLUSH;
          end
        end else begin
          blk_d = blk + BLK_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      col       <= '0;
      row       <= '0;
      blk       <= '0;
      frows     <= '0;
      done_seen <= 1'b0;
      timeout   <= 1'b0;
      newFrame  <= 1'b0;
      oValid    <= 1'b0;
      oData     <= 8'd0;
      frameDone <= 1'b0;
    end else begin
      state     <= state_d;
      col       <= col_d;
      row       <= row_d;
      blk       <= blk_d;
      frows     <= frows_d;
      done_seen <= done_seen_d;
      timeout   <= timeout_d;
      newFrame  <= new_frame_d;
      oValid    <= o_valid_d;
      oData     <= o_data_d;
      frameDone <= frame_done_d;
    end
  end

endmodule
